// File: rtl/ram_disp_pkg.sv
// Shared types and 7-segment constants for the RAM-backed decimal display.
// Segments are active-low, gfedcba in bits 6:0, bit 7 is the (always off) dp.
package ram_disp_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } conv_state_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  // Entry n holds the glyph for decimal digit n.
  localparam logic [9:0][7:0] SEG_LUT = {
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] seg_of(input logic [3:0] nib);
    logic [7:0] glyph;
    if (nib > 4'd9) begin
      glyph = SEG_DASH;
    end else begin
      glyph = SEG_LUT[nib];
    end
    return glyph;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one input bit per SHIFT cycle, then a
// single DONE cycle during which bcd holds the final result.
module bin2bcd_seq
  import ram_disp_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_W-1:0]     bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);
  localparam int unsigned BcdW = 4 * DIGITS;
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_W - 1);

  conv_state_e       state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic [BcdW-1:0]   adj;
  logic [CntW-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      sh_q    <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;

    adj = bcd_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (adj[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          sh_d    = bin;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        {bcd_d, sh_d} = {adj, sh_q} << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    bcd  = bcd_q;
    busy = (state_q == StShift);
    done = (state_q == StDone);
  end

endmodule

// File: rtl/ram_bcd_display.sv
// Single-port RAM whose registered read word is shown in decimal on DIGITS
// seven-segment digits with leading-zero blanking.
module ram_bcd_display
  import ram_disp_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wd,
  output logic [DATA_W-1:0]     rd,
  output logic [8*DIGITS-1:0]   seg,
  output logic                  busy,
  output logic                  valid
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned SegW  = 8 * DIGITS;
  localparam logic [SegW-1:0] SegReset = ~SegW'(8'h3F);
  localparam longint unsigned DecRange = 64'd10 ** DIGITS;
  localparam longint unsigned BinMax   = (64'd1 << DATA_W) - 64'd1;

  if (DecRange <= BinMax) begin : g_digits_check
    $error("ram_bcd_display: DIGITS too small to show every DATA_W value");
  end

  logic [DATA_W-1:0]   mem_q [Depth];
  logic [DATA_W-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0]   last_conv_q, last_conv_d;
  logic [DATA_W-1:0]   pend_q, pend_d;
  logic [SegW-1:0]     seg_q, seg_d;
  logic [SegW-1:0]     seg_enc;
  logic [4*DIGITS-1:0] conv_bcd;
  logic                conv_busy, conv_done, conv_idle, conv_start;
  logic                lead;
  logic [3:0]          nib;

  // Writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (!reset && we) begin
      mem_q[addr] <= wd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q        <= '0;
      last_conv_q <= '0;
      pend_q      <= '0;
      seg_q       <= SegReset;
    end else begin
      rd_q        <= rd_d;
      last_conv_q <= last_conv_d;
      pend_q      <= pend_d;
      seg_q       <= seg_d;
    end
  end

  assign conv_idle  = !conv_busy && !conv_done;
  assign conv_start = conv_idle && (rd_q != last_conv_q);

  bin2bcd_seq #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .bin   (rd_q),
    .bcd   (conv_bcd),
    .busy  (conv_busy),
    .done  (conv_done)
  );

  // Scan from the most significant digit down; the units digit is never blanked.
  always_comb begin
    lead    = 1'b1;
    nib     = '0;
    seg_enc = '1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      nib = conv_bcd[4*i +: 4];
      if (lead && nib == 4'd0) begin
        seg_enc[8*i +: 8] = SEG_BLANK;
      end else begin
        lead              = 1'b0;
        seg_enc[8*i +: 8] = seg_of(nib);
      end
    end
    seg_enc[7:0] = seg_of(conv_bcd[3:0]);
  end

  always_comb begin
    rd_d        = we ? wd : mem_q[addr];
    pend_d      = conv_start ? rd_q : pend_q;
    last_conv_d = conv_done ? pend_q : last_conv_q;
    seg_d       = conv_done ? seg_enc : seg_q;
  end

  always_comb begin
    rd    = rd_q;
    seg   = seg_q;
    busy  = conv_busy;
    valid = conv_idle && (rd_q == last_conv_q);
  end

endmodule

// File: tb/tb_ram_bcd_display.sv
// Bench for ram_bcd_display: directed scenarios plus random traffic, every
// cycle compared against a decimal-arithmetic reference model.
module tb_ram_bcd_display;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DIGITS = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [3:0]  addr;
  logic [7:0]  wd;
  logic [7:0]  rd;
  logic [23:0] seg;
  logic        busy;
  logic        valid;

  always #5 clk = ~clk;

  ram_bcd_display #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DIGITS (DIGITS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .addr  (addr),
    .wd    (wd),
    .rd    (rd),
    .seg   (seg),
    .busy  (busy),
    .valid (valid)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: memory, read register, shown value and conversion timer.
  int          m_mem [16];
  int          m_rd;
  int          m_last;
  int          m_val;
  int          m_rem;
  logic [23:0] m_seg;

  function automatic logic [7:0] glyph(input int d);
    logic [7:0] g;
    case (d)
      0: g = 8'hC0;
      1: g = 8'hF9;
      2: g = 8'hA4;
      3: g = 8'hB0;
      4: g = 8'h99;
      5: g = 8'h92;
      6: g = 8'h82;
      7: g = 8'hF8;
      8: g = 8'h80;
      9: g = 8'h90;
      default: g = 8'hBF;
    endcase
    return g;
  endfunction

  // Digit i is lit when it is the units digit or the value reaches 10**i.
  function automatic logic [23:0] seg_expect(input int v);
    logic [23:0] s;
    int p;
    p = 1;
    s = '1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (i == 0 || v >= p) s[8*i +: 8] = glyph((v / p) % 10);
      else s[8*i +: 8] = 8'hFF;
      p = p * 10;
    end
    return s;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // A change in rd starts a conversion one edge later; the new value appears
  // DATA_W + 1 edges after that start.
  task automatic model_edge(input logic r, input logic w, input logic [3:0] a,
                            input logic [7:0] d);
    if (r) begin
      m_rd   = 0;
      m_last = 0;
      m_rem  = 0;
      m_seg  = seg_expect(0);
    end else begin
      if (m_rem == 0) begin
        if (m_rd != m_last) begin
          m_val = m_rd;
          m_rem = DATA_W + 1;
        end
      end else if (m_rem == 1) begin
        m_seg  = seg_expect(m_val);
        m_last = m_val;
        m_rem  = 0;
      end else begin
        m_rem--;
      end
      if (w) begin
        m_mem[a] = int'(d);
        m_rd     = int'(d);
      end else begin
        m_rd = m_mem[a];
      end
    end
  endtask

  task automatic step(input logic r, input logic w, input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    reset = r;
    we    = w;
    addr  = a;
    wd    = d;
    @(posedge clk);
    model_edge(r, w, a, d);
    #1;
    check_eq("rd", 32'(rd), 32'(m_rd));
    check_eq("seg", 32'(seg), 32'(m_seg));
    check_eq("busy", 32'(busy), 32'(m_rem >= 2));
    check_eq("valid", 32'(valid), 32'(m_rem == 0 && m_rd == m_last));
  endtask

  initial begin
    logic [7:0] v;
    logic [3:0] ra;
    logic       rw;
    logic       rr;
    logic       saw7;

    reset = 1'b1;
    we    = 1'b0;
    addr  = '0;
    wd    = '0;
    for (int i = 0; i < 16; i++) m_mem[i] = 0;
    m_rd = 0; m_last = 0; m_val = 0; m_rem = 0; m_seg = 24'hFFFFC0;

    repeat (3) step(1'b1, 1'b0, 4'd0, 8'd0);
    check_eq("rst_seg", 32'(seg), 32'h00FFFFC0);
    check_eq("rst_rd", 32'(rd), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_valid", 32'(valid), 32'd1);

    // Fill every word so no read ever returns uninitialised data.
    for (int a = 0; a < 16; a++) begin
      if (a == 3) v = 8'd255;
      else if (a == 0) v = 8'd7;
      else if (a == 1) v = 8'd40;
      else v = 8'($urandom_range(0, 255));
      step(1'b0, 1'b1, 4'(a), v);
    end

    repeat (22) step(1'b0, 1'b0, 4'd3, 8'd0);
    check_eq("show_255", 32'(seg), 32'h00A49292);
    repeat (12) step(1'b0, 1'b0, 4'd0, 8'd0);
    check_eq("show_7", 32'(seg), 32'h00FFFFF8);
    repeat (12) step(1'b0, 1'b0, 4'd1, 8'd0);
    check_eq("show_40", 32'(seg), 32'h00FF99C0);

    // Switch address while the conversion of 7 is in flight.
    repeat (4) step(1'b0, 1'b0, 4'd0, 8'd0);
    saw7 = 1'b0;
    repeat (22) begin
      step(1'b0, 1'b0, 4'd1, 8'd0);
      if (seg == 24'hFFFFF8) saw7 = 1'b1;
    end
    check_eq("mid_saw7", 32'(saw7), 32'd1);
    check_eq("mid_final40", 32'(seg), 32'h00FF99C0);
    check_eq("mid_valid", 32'(valid), 32'd1);

    step(1'b0, 1'b1, 4'd2, 8'd100);
    check_eq("wfirst_rd", 32'(rd), 32'd100);
    repeat (11) step(1'b0, 1'b0, 4'd2, 8'd0);
    check_eq("show_100", 32'(seg), 32'h00F9C0C0);

    // Reset lands while the converter is shifting.
    repeat (4) step(1'b0, 1'b0, 4'd3, 8'd0);
    check_eq("pre_rst_busy", 32'(busy), 32'd1);
    step(1'b1, 1'b0, 4'd3, 8'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_seg", 32'(seg), 32'h00FFFFC0);
    check_eq("midrst_rd", 32'(rd), 32'd0);
    repeat (12) step(1'b0, 1'b0, 4'd3, 8'd0);
    check_eq("ram_kept", 32'(seg), 32'h00A49292);

    // A write attempted during reset must not land.
    v = 8'(m_mem[5]);
    step(1'b1, 1'b1, 4'd5, ~v);
    repeat (2) step(1'b0, 1'b0, 4'd5, 8'd0);
    check_eq("rst_we_ignored", 32'(rd), 32'(v));

    repeat (60) begin
      ra = 4'($urandom_range(0, 15));
      rw = ($urandom_range(0, 3) == 0);
      rr = ($urandom_range(0, 40) == 0);
      v  = 8'($urandom_range(0, 255));
      step(rr, rw, ra, v);
      repeat ($urandom_range(0, 13)) step(1'b0, 1'b0, ra, 8'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_bcd_display.md
Name: ram_bcd_display

Overview:
- Parametrised single-port RAM with a decimal readout on a multi-digit 7-segment display.
- The read port feeds a sequential double-dabble binary-to-BCD converter. The converter drives DIGITS registered segment bytes with leading-zero blanking.
- Sits at top level on the demo board: switches drive we/addr/wd; seg drives the indicator bank.

Parameters:
- DATA_W, 8, RAM word width and converter input width (2..16).
- ADDR_W, 4, address width; depth = 2**ADDR_W.
- DIGITS, 3, number of decimal digits displayed. Must satisfy 10**DIGITS > 2**DATA_W-1; elaboration-time assertion.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- we  in  1  write enable.
- addr  in  ADDR_W  read/write address.
- wd  in  DATA_W  write data.
- rd  out  DATA_W  registered read data.
- seg  out  8*DIGITS  segment bytes. Digit i occupies seg[8i+7:8i]; digit 0 = units. Active-low, bit7 = dp (always 1 = off).
- busy  out  1  converter running.
- valid  out  1  seg reflects the current rd.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on port reset.
- Reset values:
  - rd = 0, busy = 0, valid = 1.
  - seg shows "0": digit0 = 8'hC0, other digits blank (8'hFF).
  - last_conv register = 0.
  - RAM array is not cleared.
- RAM:
  - Write at the clock edge when we = 1: mem[addr] <= wd.
  - rd <= mem[addr] every cycle, 1-cycle latency.
  - Write-first: if we = 1, rd <= wd in the same edge.
- Converter FSM, states IDLE, SHIFT, DONE:
  - IDLE: if rd != last_conv, latch sh <= rd and clear the BCD accumulator. Set busy = 1, valid = 0, cnt = 0. Go to SHIFT.
  - SHIFT, one bit per cycle: add 3 to every BCD nibble >= 5, then shift {bcd, sh} left by 1, cnt++. After DATA_W shifts go to DONE.
  - DONE, one cycle: update seg from the BCD nibbles, last_conv <= latched value, busy = 0. Go to IDLE. valid = 1 from the next cycle if rd == last_conv.
  - valid is combinational: !busy && rd == last_conv && state == IDLE.
- Latency: rd change (edge t) → conversion start (t+1) → DATA_W SHIFT cycles → DONE → seg updated at edge t+DATA_W+2. For DATA_W = 8, seg changes 10 cycles after rd.
- rd changes mid-conversion: the conversion in flight completes with its latched value and seg shows it. IDLE then sees the mismatch and restarts immediately. No abort, no lost final value.
- Blanking:
  - Digit i (i > 0) is blank (8'hFF) if it and all digits above it are zero.
  - Units digit is always shown.
  - Nibble values > 9 cannot occur; if they do, encode as 8'hBF ("-") for fault visibility.
- Segment encoding, active-low, gfedcba in bits 6:0:
  - 0 = C0, 1 = F9, 2 = A4, 3 = B0, 4 = 99
  - 5 = 92, 6 = 82, 7 = F8, 8 = 80, 9 = 90
- Arithmetic:
  - BCD accumulator is 4*DIGITS bits; shift-in never overflows given the DIGITS constraint.
  - cnt width is $clog2(DATA_W+1).
- Reset mid-conversion: FSM returns to IDLE and all outputs take their reset values on the same edge.
- Reset held: we is ignored (no RAM write while reset = 1).

Decomposition:
- Package ram_disp_pkg:
  - fsm state enum (IDLE, SHIFT, DONE).
  - SEG_BLANK = 8'hFF, SEG_DASH = 8'hBF.
  - 10-entry seg lookup constant.
  - function seg_of(nibble).
- Sub-module bin2bcd_seq (params DATA_W, DIGITS):
  - Inputs: clk, reset, start, bin.
  - Outputs: bcd, busy, done.
  - Contains the FSM and shift/add-3 datapath.
- Blanking and encoding stay in the top module.

Test Plan:
- Reset with default params → rd = 0, seg = {FF,FF,C0}, busy = 0, valid = 1.
- Write 8'd255 to addr 3, then read addr 3 → rd = 255 one edge after the addr settles. seg = {A4,92,92} ("255") exactly 10 cycles after the rd change; busy high for those cycles.
- Write 7 to addr 0 and 40 to addr 1. Read addr 0 → seg {FF,FF,F8}. Read addr 1 → {FF,99,C0}. Confirms blanking of a middle/upper zero digit versus an internal zero.
- Switch addr 0→1 three cycles into a conversion (values 7, 40) → seg shows "7", then "40" within 2×10 cycles. valid low until the final conversion completes.
- we = 1 with addr = 2, wd = 100 → rd = 100 on the same edge (write-first). seg = {F9,C0,C0} after 10 cycles.
- Assert reset during SHIFT → next edge: busy = 0, seg = "0", rd = 0. Previously written RAM data is still readable afterwards.
